uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Serial receiver for the UART: recovers frames on the serial line produced by the UART transmitter and presents each received word in parallel with status flags. It takes the same frame configuration inputs as the transmitter (baud select, parity type, stop bits, data length), so a transmitter/receiver pair configured identically interoperates. It sits at the pin side of the design, between the asynchronous serial input and the parallel consumer logic, on the single 50 MHz system clock.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency. Divisors below are fixed for this value.
- `OVERSAMPLE`, 16, sample ticks per bit period.
- `Clock` input 1: system clock, 50 MHz, rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `SerialIn` input 1: asynchronous serial line. Idle is high.
- `BaudRate` input 2: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- `ParityType` input 2: 01 = odd, 10 = even, 00/11 = no parity bit.
- `StopBits` input 1: 0 = one stop bit, 1 = two stop bits.
- `DataLength` input 1: 0 = 7 data bits, 1 = 8 data bits.
- `DataOut` output 8: last received word, LSB-aligned. Bit 7 is 0 in 7-bit mode.
- `ErrorFlag` output 2: [0] parity error, [1] framing (stop) error, for the last frame.
- `ActiveFlag` output 1: high while a frame is being received.
- `DoneFlag` output 1: one-cycle pulse when a frame completes.

## Operation
- **Input synchronizer**: `SerialIn` passes through 2 flops, both reset to 1. All logic uses the synchronized line.
- **Tick generator**: a divisor counter produces one tick every D clocks.
  - D = 1302 / 651 / 326 / 163 for BaudRate 00 / 01 / 10 / 11.
  - The counter is cleared on start detection so the tick phase is aligned to the frame.
- **Per-frame configuration**: BaudRate, ParityType, StopBits and DataLength are latched on start detection. Changes during a frame take effect on the next frame.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the synchronized line at 0 → START. Clear the tick counter and the divisor counter; set ActiveFlag.
  - START: at tick 8, sample the line.
    - 0 → DATA, with the tick count restarted.
    - 1 → glitch: return to IDLE, no DoneFlag, flags unchanged.
  - DATA: sample every 16 ticks (mid-bit) and shift in LSB first. After 7 or 8 bits (latched DataLength) → PARITY if parity is enabled, else → STOP.
  - PARITY: sample 16 ticks after the last data bit.
    - Error if the sampled bit ≠ the required bit.
    - Odd parity: data bits XOR parity bit must equal 1. Even parity: the XOR must equal 0.
  - STOP: sample 1 or 2 stop bits, 16 ticks apart.
    - A framing error is flagged if any sampled stop bit is 0.
    - After the last stop sample: update outputs, pulse DoneFlag, clear ActiveFlag, → IDLE.
- **Output update**: DataOut and ErrorFlag update together, only on frame completion, and hold until the next completion. A frame with errors still updates DataOut.
- **Break condition** (line held low): IDLE re-triggers immediately. This yields repeated frames with data 0 and a framing error.

## Timing
- **Reset values**: DataOut = 0, ErrorFlag = 0, ActiveFlag = 0, DoneFlag = 0; FSM in IDLE. Reset mid-frame aborts the frame: no DoneFlag, outputs cleared.
- **Start latency**: start detection occurs 2–3 clocks after the `SerialIn` falling edge (synchronizer). ActiveFlag rises the cycle after detection.
- **Sample points**: at 8 + 16·k ticks after detection. Bit period = 16·D clocks, e.g. 5216 clocks at 9600 baud.
- **Completion**: DoneFlag is high for exactly one clock, the cycle after the last stop-bit sample. DataOut, ErrorFlag and the falling ActiveFlag are valid in that same cycle.
- **Back-to-back frames**: the receiver returns to IDLE at mid-stop-bit, so it accepts a next start bit that immediately follows the stop bit(s) with no idle time.
- **Baud tolerance**: sampling stays inside the bit for ±3% baud mismatch on an 11-bit frame.

## Test plan
- **8N1 at 9600**: 8N1 frame 0xA5 (BaudRate 10, ParityType 00, StopBits 0, DataLength 1) → single DoneFlag pulse; DataOut = 0xA5, ErrorFlag = 00; ActiveFlag high for about 9.5 bit periods.
- **Odd parity at 2400**: 8O1 frame 0x55 with correct parity bit 1 → DataOut = 0x55, ErrorFlag = 00. Repeat with the parity bit inverted → DataOut = 0x55, ErrorFlag = 01.
- **7-bit, even parity, 2 stop bits at 19200**: 0x3C with correct parity 0 → DataOut = 0x3C, ErrorFlag = 00. Repeat with the second stop bit driven 0 → ErrorFlag = 10.
- **Glitch rejection**: a low pulse of 4·D clocks on an idle line → ActiveFlag pulses, no DoneFlag; DataOut and ErrorFlag are unchanged.
- **Back-to-back frames**: two consecutive 8N1 frames 0x0F then 0xF0 with no idle gap → two DoneFlag pulses about 10 bit periods apart, with DataOut 0x0F then 0xF0.
- **Reset mid-frame**: Reset asserted during DATA for 1 clock → all outputs 0 the next cycle and no DoneFlag. A subsequent 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_unit
// Function : 16x-oversampling UART receiver with per-frame latched format and
//            parity/framing status for each completed frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_unit #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SerialIn,
  input  logic [1:0] BaudRate,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic [1:0] ErrorFlag,
  output logic       ActiveFlag,
  output logic       DoneFlag
);

  localparam int c_TICK_W = $clog2(OVERSAMPLE);

  // Rounded divisors: 1302 / 651 / 326 / 163 at 50 MHz
  localparam logic [15:0] c_DIV_2400  = 16'((CLK_HZ + (2400  * OVERSAMPLE) / 2) / (2400  * OVERSAMPLE));
  localparam logic [15:0] c_DIV_4800  = 16'((CLK_HZ + (4800  * OVERSAMPLE) / 2) / (4800  * OVERSAMPLE));
  localparam logic [15:0] c_DIV_9600  = 16'((CLK_HZ + (9600  * OVERSAMPLE) / 2) / (9600  * OVERSAMPLE));
  localparam logic [15:0] c_DIV_19200 = 16'((CLK_HZ + (19200 * OVERSAMPLE) / 2) / (19200 * OVERSAMPLE));

  localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_FULL_LAST = c_TICK_W'(OVERSAMPLE - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_nextState;
  logic                r_sync1;
  logic                r_rxd;
  logic [1:0]          r_baudSel;
  logic [1:0]          r_parType;
  logic                r_twoStop;
  logic                r_eightBit;
  logic [15:0]         r_divCount;
  logic [15:0]         w_divisor;
  logic [c_TICK_W-1:0] r_tickCount;
  logic [2:0]          r_bitCount;
  logic                r_stopCount;
  logic [7:0]          r_shift;
  logic                r_parErr;
  logic                r_frameErr;
  logic [7:0]          r_dataOut;
  logic [1:0]          r_errorFlag;
  logic                r_done;

  logic w_tick;
  logic w_samplePoint;
  logic w_lastData;
  logic w_lastStop;
  logic w_parityEn;
  logic w_startDet;
  logic w_finish;
  logic w_active;

  always_comb begin
    case (r_baudSel)
      2'b00:   w_divisor = c_DIV_2400;
      2'b01:   w_divisor = c_DIV_4800;
      2'b10:   w_divisor = c_DIV_9600;
      default: w_divisor = c_DIV_19200;
    endcase
  end

  // The start bit is sampled after half a bit, every later bit after a full one
  assign w_tick        = (r_divCount == (w_divisor - 16'd1));
  assign w_samplePoint = w_tick &&
                         (r_tickCount == ((r_state == c_START) ? c_HALF_LAST : c_FULL_LAST));
  assign w_lastData    = (r_bitCount == (r_eightBit ? 3'd7 : 3'd6));
  assign w_lastStop    = (r_stopCount == r_twoStop);
  assign w_parityEn    = (r_parType == 2'b01) || (r_parType == 2'b10);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (!r_rxd) w_nextState = c_START;
      end
      c_START: begin
        if (w_samplePoint) w_nextState = r_rxd ? c_IDLE : c_DATA;
      end
      c_DATA: begin
        if (w_samplePoint && w_lastData) w_nextState = w_parityEn ? c_PARITY : c_STOP;
      end
      c_PARITY: begin
        if (w_samplePoint) w_nextState = c_STOP;
      end
      c_STOP: begin
        if (w_samplePoint && w_lastStop) w_nextState = c_IDLE;
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  // ------------------------------------------------------------- state decode
  always_comb begin
    w_active   = 1'b0;
    w_startDet = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_startDet = !r_rxd;
      end
      c_STOP: begin
        w_active = 1'b1;
        w_finish = w_samplePoint && w_lastStop;
      end
      default: begin
        w_active = 1'b1;
      end
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1     <= 1'b1;
      r_rxd       <= 1'b1;
      r_baudSel   <= 2'b00;
      r_parType   <= 2'b00;
      r_twoStop   <= 1'b0;
      r_eightBit  <= 1'b0;
      r_divCount  <= 16'd0;
      r_tickCount <= '0;
      r_bitCount  <= 3'd0;
      r_stopCount <= 1'b0;
      r_shift     <= 8'd0;
      r_parErr    <= 1'b0;
      r_frameErr  <= 1'b0;
      r_dataOut   <= 8'd0;
      r_errorFlag <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      r_sync1 <= SerialIn;
      r_rxd   <= r_sync1;
      r_done  <= w_finish;

      // Frame format is frozen at the start edge; mid-frame changes wait
      if (w_startDet) begin
        r_baudSel   <= BaudRate;
        r_parType   <= ParityType;
        r_twoStop   <= StopBits;
        r_eightBit  <= DataLength;
        r_divCount  <= 16'd0;
        r_tickCount <= '0;
        r_bitCount  <= 3'd0;
        r_stopCount <= 1'b0;
        r_shift     <= 8'd0;
        r_parErr    <= 1'b0;
        r_frameErr  <= 1'b0;
      end else if (r_state != c_IDLE) begin
        r_divCount <= w_tick ? 16'd0 : (r_divCount + 16'd1);
        if (w_tick) begin
          r_tickCount <= w_samplePoint ? '0 : (r_tickCount + 1'b1);
        end
      end

      if (w_samplePoint) begin
        case (r_state)
          c_DATA: begin
            r_shift    <= {r_rxd, r_shift[7:1]};
            r_bitCount <= r_bitCount + 3'd1;
          end
          c_PARITY: begin
            r_parErr <= (((^r_shift) ^ r_rxd) != (r_parType == 2'b01));
          end
          c_STOP: begin
            r_stopCount <= ~r_stopCount;
            if (!r_rxd) r_frameErr <= 1'b1;
          end
          default: begin
          end
        endcase
      end

      // In 7-bit mode the word sits in [7:1] with a zero shifted into bit 0
      if (w_finish) begin
        r_dataOut   <= r_eightBit ? r_shift : {1'b0, r_shift[7:1]};
        r_errorFlag <= {r_frameErr | ~r_rxd, r_parErr};
      end
    end
  end

  assign DataOut    = r_dataOut;
  assign ErrorFlag  = r_errorFlag;
  assign ActiveFlag = w_active;
  assign DoneFlag   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_unit
// Function : Directed and randomized frames against a frame-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_unit;

  // Reduced clock so slow baud rates stay short in simulation
  localparam int c_CLK_HZ = 1_600_000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       SerialIn = 1'b1;
  logic [1:0] BaudRate = 2'b10;
  logic [1:0] ParityType = 2'b00;
  logic       StopBits = 1'b0;
  logic       DataLength = 1'b1;
  logic [7:0] DataOut;
  logic [1:0] ErrorFlag;
  logic       ActiveFlag;
  logic       DoneFlag;

  int nCompared = 0;
  int nMismatched = 0;

  uart_rx_unit #(
    .CLK_HZ     (c_CLK_HZ),
    .OVERSAMPLE (16)
  ) u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SerialIn   (SerialIn),
    .BaudRate   (BaudRate),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .DataLength (DataLength),
    .DataOut    (DataOut),
    .ErrorFlag  (ErrorFlag),
    .ActiveFlag (ActiveFlag),
    .DoneFlag   (DoneFlag)
  );

  always #5 Clock = ~Clock;

  // ------------------------------------------------------------ monitor
  int          cycle = 0;
  int          activeRun = 0;
  int          activeRises = 0;
  logic        prevActive = 1'b0;
  logic [10:0] doneQ[$];
  int          doneCycle[$];
  int          activeLenQ[$];

  always @(negedge Clock) begin
    cycle++;
    if (ActiveFlag && !prevActive) activeRises++;
    prevActive = ActiveFlag;
    if (DoneFlag) begin
      doneQ.push_back({ActiveFlag, ErrorFlag, DataOut});
      doneCycle.push_back(cycle);
      activeLenQ.push_back(activeRun);
      activeRun = 0;
    end else if (ActiveFlag) begin
      activeRun++;
    end else begin
      activeRun = 0;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ helpers
  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Divisor per BaudRate code at c_CLK_HZ: round(CLK_HZ / (16 * baud))
  function automatic int divOf(input logic [1:0] b);
    case (b)
      2'b00:   return 42;
      2'b01:   return 21;
      2'b10:   return 10;
      default: return 5;
    endcase
  endfunction

  function automatic logic parityOn(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  function automatic logic goodParity(input logic [1:0] par, input logic [7:0] word);
    return (par == 2'b01) ? ~(^word) : (^word);
  endfunction

  // Expected {framing, parity, word} for one frame on the wire
  function automatic logic [9:0] refFrame(input logic [1:0] par, input logic two, input logic len,
                                          input logic [7:0] data, input logic pbit,
                                          input logic s1, input logic s2);
    logic [7:0] word;
    logic       perr;
    logic       ferr;
    word = len ? data : {1'b0, data[6:0]};
    perr = 1'b0;
    if (par == 2'b01) perr = (((^word) ^ pbit) != 1'b1);
    if (par == 2'b10) perr = (((^word) ^ pbit) != 1'b0);
    ferr = !s1 || (two && !s2);
    return {ferr, perr, word};
  endfunction

  // Active time runs from detection to the last stop-bit mid-point
  function automatic int expLenOf(input logic len, input logic [1:0] par, input logic two, input int d);
    int nBits;
    nBits = (len ? 8 : 7) + (parityOn(par) ? 1 : 0) + (two ? 2 : 1);
    return (8 + 16 * nBits) * d;
  endfunction

  function automatic int inWindow(input int obs, input int exp, input int tol);
    return (obs >= exp - tol && obs <= exp + tol) ? exp : obs;
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic driveBit(input logic b, input int d);
    SerialIn = b;
    waitClk(16 * d);
  endtask

  task automatic sendFrame(input logic [1:0] baud, input logic [1:0] par, input logic two,
                           input logic len, input logic [7:0] data, input logic pbit,
                           input logic s1, input logic s2, input bit scramble);
    int d;
    d = divOf(baud);
    BaudRate   = baud;
    ParityType = par;
    StopBits   = two;
    DataLength = len;
    SerialIn   = 1'b0;
    waitClk(8);
    if (scramble) begin
      BaudRate   = 2'($urandom);
      ParityType = 2'($urandom);
      StopBits   = 1'($urandom);
      DataLength = 1'($urandom);
    end
    waitClk(16 * d - 8);
    for (int i = 0; i < (len ? 8 : 7); i++) driveBit(data[i], d);
    if (parityOn(par)) driveBit(pbit, d);
    BaudRate   = baud;
    ParityType = par;
    StopBits   = two;
    DataLength = len;
    driveBit(s1, d);
    if (two) driveBit(s2, d);
    SerialIn = 1'b1;
  endtask

  task automatic clearMon();
    doneQ.delete();
    doneCycle.delete();
    activeLenQ.delete();
  endtask

  task automatic expectDone(input string tag, input logic [9:0] exp, input int expLen);
    logic [10:0] item;
    int          len;
    checkVal({tag, " done-count"}, 32'(doneQ.size()), 32'd1);
    if (doneQ.size() > 0) begin
      item = doneQ.pop_front();
      len  = activeLenQ.pop_front();
      checkVal({tag, " data"}, 32'(item[7:0]), 32'(exp[7:0]));
      checkVal({tag, " err"}, 32'(item[9:8]), 32'(exp[9:8]));
      checkVal({tag, " active-at-done"}, 32'(item[10]), 32'd0);
      checkVal({tag, " active-len"}, 32'(inWindow(len, expLen, 3)), 32'(expLen));
    end
    clearMon();
  endtask

  // ------------------------------------------------------------ stimulus
  logic [10:0] item;
  logic [1:0]  rBaud;
  logic [1:0]  rPar;
  logic        rTwo;
  logic        rLen;
  logic        rP;
  logic        rS1;
  logic        rS2;
  logic [7:0]  rData;
  int          rD;
  int          rises0;

  initial begin
    waitClk(3);
    Reset = 1'b0;
    waitClk(1);
    checkVal("reset DataOut", 32'(DataOut), 32'd0);
    checkVal("reset ErrorFlag", 32'(ErrorFlag), 32'd0);
    checkVal("reset ActiveFlag", 32'(ActiveFlag), 32'd0);
    checkVal("reset DoneFlag", 32'(DoneFlag), 32'd0);
    waitClk(20);
    clearMon();

    // 8N1 at 9600
    sendFrame(2'b10, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    expectDone("8N1 A5", {2'b00, 8'hA5}, 152 * 10);

    // 8O1 at 2400, good then bad parity
    sendFrame(2'b00, 2'b01, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    expectDone("8O1 good", {2'b00, 8'h55}, 168 * 42);
    sendFrame(2'b00, 2'b01, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    expectDone("8O1 bad", {2'b01, 8'h55}, 168 * 42);

    // 7E2 at 19200, good then bad second stop bit
    sendFrame(2'b11, 2'b10, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    expectDone("7E2 good", {2'b00, 8'h3C}, 168 * 5);
    sendFrame(2'b11, 2'b10, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    expectDone("7E2 stop", {2'b10, 8'h3C}, 168 * 5);
    waitClk(32 * 5);
    clearMon();

    // Glitch of 4 ticks at 9600
    BaudRate = 2'b10;
    rises0 = activeRises;
    SerialIn = 1'b0;
    waitClk(40);
    SerialIn = 1'b1;
    waitClk(3 * 160);
    checkVal("glitch active-pulse", 32'(activeRises - rises0), 32'd1);
    checkVal("glitch done-count", 32'(doneQ.size()), 32'd0);
    checkVal("glitch DataOut", 32'(DataOut), 32'h3C);
    checkVal("glitch ErrorFlag", 32'(ErrorFlag), 32'h2);
    clearMon();

    // Back-to-back 8N1 frames with no idle gap
    sendFrame(2'b10, 2'b00, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
    sendFrame(2'b10, 2'b00, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("b2b done-count", 32'(doneQ.size()), 32'd2);
    if (doneQ.size() == 2) begin
      checkVal("b2b spacing", 32'(inWindow(doneCycle[1] - doneCycle[0], 1600, 2)), 32'd1600);
      item = doneQ.pop_front();
      checkVal("b2b first data", 32'(item[7:0]), 32'h0F);
      checkVal("b2b first err", 32'(item[9:8]), 32'd0);
      item = doneQ.pop_front();
      checkVal("b2b second data", 32'(item[7:0]), 32'hF0);
      checkVal("b2b second err", 32'(item[9:8]), 32'd0);
    end
    clearMon();

    // Reset during the data bits
    BaudRate   = 2'b10;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    SerialIn   = 1'b0;
    waitClk(4 * 160 + 8);
    checkVal("midframe active", 32'(ActiveFlag), 32'd1);
    SerialIn = 1'b1;
    Reset    = 1'b1;
    waitClk(1);
    Reset = 1'b0;
    checkVal("midreset DataOut", 32'(DataOut), 32'd0);
    checkVal("midreset ErrorFlag", 32'(ErrorFlag), 32'd0);
    checkVal("midreset ActiveFlag", 32'(ActiveFlag), 32'd0);
    checkVal("midreset DoneFlag", 32'(DoneFlag), 32'd0);
    waitClk(12 * 160);
    checkVal("midreset done-count", 32'(doneQ.size()), 32'd0);
    clearMon();
    sendFrame(2'b10, 2'b00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
    expectDone("after-reset 81", {2'b00, 8'h81}, 152 * 10);

    // Randomized frames, format inputs scrambled mid-frame
    for (int n = 0; n < 8; n++) begin
      rBaud = 2'($urandom_range(1, 3));
      rPar  = 2'($urandom);
      rTwo  = 1'($urandom);
      rLen  = 1'($urandom);
      rData = 8'($urandom);
      rP    = goodParity(rPar, rLen ? rData : {1'b0, rData[6:0]}) ^ ($urandom_range(0, 3) == 0);
      rS1   = ($urandom_range(0, 4) != 0);
      rS2   = ($urandom_range(0, 4) != 0);
      rD    = divOf(rBaud);
      sendFrame(rBaud, rPar, rTwo, rLen, rData, rP, rS1, rS2, 1'b1);
      expectDone($sformatf("rand%0d", n), refFrame(rPar, rTwo, rLen, rData, rP, rS1, rS2),
                 expLenOf(rLen, rPar, rTwo, rD));
      if (rTwo ? !rS2 : !rS1) begin
        waitClk(32 * rD);
      end else begin
        waitClk($urandom_range(0, 3) * rD);
      end
      clearMon();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
